// File: rtl/axil_test_master_pkg.sv
// rtl/axil_test_master_pkg.sv - shared types and constants for the AXI4-Lite test master
package axil_test_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WADDR  = 3'd1,
        WRESP  = 3'd2,
        RADDR  = 3'd3,
        RDATA  = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Pattern increment: 0x01 in every byte lane of a data_width-bit word
    function automatic logic [63:0] step_const(input int data_width);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < data_width / 8; i++) begin
            s[8*i +: 8] = 8'h01;
        end
        return s;
    endfunction

endpackage

// File: rtl/axil_test_master_if.sv
// rtl/axil_test_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_test_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axil_pattern_gen.sv
// rtl/axil_pattern_gen.sv - expected register contents: seed + idx * STEP
module axil_pattern_gen
    import axil_test_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [7:0]            idx,
    output logic [DATA_WIDTH-1:0] data
);

    localparam logic [63:0]           STEP64 = step_const(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] STEP   = STEP64[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] idx_ext;

    assign idx_ext = {{(DATA_WIDTH-8){1'b0}}, idx};
    // Wraps modulo 2^DATA_WIDTH by construction of the result width
    assign data    = seed + idx_ext * STEP;

endmodule

// File: rtl/axil_test_master.sv
// rtl/axil_test_master.sv - AXI4-Lite write/read-back register test master
module axil_test_master
    import axil_test_master_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MODE       = 0,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [7:0]            first_err_idx,
    axil_test_master_if.master    m_axi
);

    localparam logic [7:0]            LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] BYTES    = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [31:0]           TMO_LAST = 32'(TIMEOUT - 1);

    state_t                state;
    logic [7:0]            idx;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [31:0]           wait_cnt;
    logic                  aw_done, w_done;
    logic                  awvalid, wvalid, bready, arvalid, rready;
    logic                  aw_hs, w_hs, advance, waiting, tmo_hit, err_hit, last;

    axil_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern_gen (
        .seed (seed_q),
        .idx  (idx),
        .data (exp_data)
    );

    assign reg_addr = BASE_ADDR + ADDR_WIDTH'(idx) * BYTES;
    assign last     = (idx == LAST_IDX);
    assign aw_hs    = awvalid && m_axi.M_AXI_AWREADY;
    assign w_hs     = wvalid && m_axi.M_AXI_WREADY;
    assign waiting  = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
    assign tmo_hit  = waiting && !advance && (wait_cnt == TMO_LAST);
    // A read with both a bad response and bad data still counts as one error
    assign err_hit  = ((state == WRESP) && m_axi.M_AXI_BVALID && (m_axi.M_AXI_BRESP != RESP_OKAY)) ||
                      ((state == RDATA) && m_axi.M_AXI_RVALID &&
                       ((m_axi.M_AXI_RRESP != RESP_OKAY) || (m_axi.M_AXI_RDATA != exp_data)));

    // Payloads derive from state and idx, which only change on state exits, so they hold while VALID is up
    assign m_axi.M_AXI_AWADDR  = (state == WADDR) ? reg_addr : '0;
    assign m_axi.M_AXI_WDATA   = (state == WADDR) ? exp_data : '0;
    assign m_axi.M_AXI_WSTRB   = (state == WADDR) ? '1 : '0;
    assign m_axi.M_AXI_ARADDR  = (state == RADDR) ? reg_addr : '0;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid;
    assign m_axi.M_AXI_WVALID  = wvalid;
    assign m_axi.M_AXI_BREADY  = bready;
    assign m_axi.M_AXI_ARVALID = arvalid;
    assign m_axi.M_AXI_RREADY  = rready;

    // Per-state completion of the handshake the FSM is waiting on
    always_comb begin
        advance = 1'b0;
        case (state)
            WADDR:   advance = (aw_done || aw_hs) && (w_done || w_hs);
            WRESP:   advance = m_axi.M_AXI_BVALID;
            RADDR:   advance = m_axi.M_AXI_ARREADY;
            RDATA:   advance = m_axi.M_AXI_RVALID;
            default: advance = 1'b0;
        endcase
    end

    // Main sequencer: drives the AXI handshakes and run status
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            idx      <= '0;
            seed_q   <= '0;
            wait_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q  <= seed;
                        idx     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WADDR;
                    end
                end
                WADDR: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (advance) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (advance) begin
                        bready <= 1'b0;
                        if (MODE == 0 || last) begin
                            if (MODE != 0) idx <= '0;
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end else begin
                            idx     <= idx + 8'd1;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (advance) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (advance) begin
                        rready <= 1'b0;
                        if (last) begin
                            state <= FINISH;
                        end else if (MODE == 0) begin
                            idx     <= idx + 8'd1;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WADDR;
                        end else begin
                            idx     <= idx + 8'd1;
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == 16'd0) && !timeout;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (advance || !waiting) wait_cnt <= '0;
            else                     wait_cnt <= wait_cnt + 32'd1;

            // A stalled handshake abandons the run; overrides anything set above
            if (tmo_hit) begin
                timeout <= 1'b1;
                awvalid <= 1'b0;
                wvalid  <= 1'b0;
                bready  <= 1'b0;
                arvalid <= 1'b0;
                rready  <= 1'b0;
                state   <= FINISH;
            end
        end
    end

    // Error bookkeeping: saturating count and index of the first failing register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_count     <= '0;
            first_err_idx <= '0;
        end else if (state == IDLE && start) begin
            err_count     <= '0;
            first_err_idx <= '0;
        end else if (err_hit) begin
            if (err_count == 16'd0)     first_err_idx <= idx;
            if (err_count != 16'hFFFF)  err_count     <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axil_test_master.sv
// tb/tb_axil_test_master.sv - directed bench for axil_test_master in both modes
module tb_axil_test_master;

    logic tb_ACLK    = 1'b0;
    logic tb_ARESETN = 1'b0;

    always #5 tb_ACLK = ~tb_ACLK;

    logic [1:0]            start, busy, done, pass, tmo;
    logic [1:0][31:0]      seed;
    logic [1:0][15:0]      err_count;
    logic [1:0][7:0]       first_err_idx;
    logic [1:0][7:0]       aw_delay, w_delay;
    logic [1:0]            no_b, corrupt_en;
    logic [1:0]            any_vr, rready_v, bready_v, payload_nz;
    logic [1:0][7:0]       n_aw_v, n_w_v, n_ar_v, aw_before_ar_v;
    logic [1:0][3:0][31:0] aw_log_v, w_log_v;

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : gi
        axil_test_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        axil_test_master #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .NUM_REGS   (4),
            .BASE_ADDR  (32'h0),
            .MODE       (g),
            .TIMEOUT    (16)
        ) u_dut (
            .ACLK          (tb_ACLK),
            .ARESETN       (tb_ARESETN),
            .start         (start[g]),
            .seed          (seed[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .pass          (pass[g]),
            .timeout       (tmo[g]),
            .err_count     (err_count[g]),
            .first_err_idx (first_err_idx[g]),
            .m_axi         (bus)
        );

        logic [31:0]      mem [0:15];
        int               aw_cnt, w_cnt;
        logic             aw_pend, w_pend, bvalid_q, rvalid_q;
        logic [31:0]      aw_addr_q, w_data_q, rdata_q;
        logic [7:0]       n_aw, n_w, n_ar, aw_before_ar;
        logic [3:0][31:0] aw_log, w_log;

        assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && !aw_pend && (aw_cnt >= int'(aw_delay[g]));
        assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && !w_pend && (w_cnt >= int'(w_delay[g]));
        assign bus.M_AXI_BVALID  = bvalid_q;
        assign bus.M_AXI_BRESP   = 2'b00;
        assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !rvalid_q;
        assign bus.M_AXI_RVALID  = rvalid_q;
        assign bus.M_AXI_RDATA   = rdata_q;
        assign bus.M_AXI_RRESP   = 2'b00;

        assign any_vr[g]     = bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_BREADY |
                               bus.M_AXI_ARVALID | bus.M_AXI_RREADY;
        assign rready_v[g]   = bus.M_AXI_RREADY;
        assign bready_v[g]   = bus.M_AXI_BREADY;
        assign payload_nz[g] = (|bus.M_AXI_AWADDR) | (|bus.M_AXI_ARADDR) | (|bus.M_AXI_WDATA);
        assign n_aw_v[g]         = n_aw;
        assign n_w_v[g]          = n_w;
        assign n_ar_v[g]         = n_ar;
        assign aw_before_ar_v[g] = aw_before_ar;
        assign aw_log_v[g]       = aw_log;
        assign w_log_v[g]        = w_log;

        always @(posedge tb_ACLK or negedge tb_ARESETN) begin
            if (!tb_ARESETN) begin
                aw_cnt <= 0; w_cnt <= 0; aw_pend <= 1'b0; w_pend <= 1'b0;
                bvalid_q <= 1'b0; rvalid_q <= 1'b0; aw_addr_q <= '0; w_data_q <= '0; rdata_q <= '0;
                n_aw <= '0; n_w <= '0; n_ar <= '0; aw_before_ar <= '0; aw_log <= '0; w_log <= '0;
            end else begin
                if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                    aw_pend <= 1'b1; aw_addr_q <= bus.M_AXI_AWADDR; aw_cnt <= 0;
                    if (n_aw < 8'd4) aw_log[n_aw[1:0]] <= bus.M_AXI_AWADDR;
                    n_aw <= n_aw + 8'd1;
                end else if (bus.M_AXI_AWVALID) begin
                    aw_cnt <= aw_cnt + 1;
                end
                if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                    w_pend <= 1'b1; w_data_q <= bus.M_AXI_WDATA; w_cnt <= 0;
                    if (n_w < 8'd4) w_log[n_w[1:0]] <= bus.M_AXI_WDATA;
                    n_w <= n_w + 8'd1;
                end else if (bus.M_AXI_WVALID) begin
                    w_cnt <= w_cnt + 1;
                end
                if (bvalid_q && bus.M_AXI_BREADY) begin
                    bvalid_q <= 1'b0;
                end else if (aw_pend && w_pend && !bvalid_q && !no_b[g]) begin
                    mem[aw_addr_q[5:2]] <= w_data_q;
                    bvalid_q <= 1'b1; aw_pend <= 1'b0; w_pend <= 1'b0;
                end
                if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                    if (n_ar == 8'd0) aw_before_ar <= n_aw;
                    n_ar     <= n_ar + 8'd1;
                    rdata_q  <= mem[bus.M_AXI_ARADDR[5:2]] ^
                                ((corrupt_en[g] && bus.M_AXI_ARADDR[5:2] == 4'd2) ? 32'h0000_0100 : 32'h0);
                    rvalid_q <= 1'b1;
                end else if (rvalid_q && bus.M_AXI_RREADY) begin
                    rvalid_q <= 1'b0;
                end
            end
        end
    end

    logic [31:0] exp039 [4] = '{32'h0101FFFF, 32'h02030100, 32'h03040201, 32'h04050302};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        tb_ARESETN = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
    endtask

    task automatic run(input int g, input logic [31:0] s, input bit glitch, output int bcyc);
        bit ok;
        ok   = 1'b0;
        bcyc = 0;
        @(negedge tb_ACLK);
        seed[g]  = s;
        start[g] = 1'b1;
        @(negedge tb_ACLK);
        start[g] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done[g]) begin
                ok = 1'b1;
                break;
            end
            if (bready_v[g]) bcyc++;
            if (glitch && i == 3) begin
                seed[g]  = 32'hDEADBEEF;
                start[g] = 1'b1;
            end
            if (glitch && i == 4) start[g] = 1'b0;
            @(negedge tb_ACLK);
        end
        check($sformatf("done_seen_dut%0d", g), 32'(ok), 32'd1);
    endtask

    initial begin
        int  bc;
        bit  seen;
        start = '0; seed = '0; aw_delay = '0; w_delay = '0; no_b = '0; corrupt_en = '0;
        do_reset();

        check("rst_status0", {28'd0, busy[0], done[0], pass[0], tmo[0]}, 32'd0);
        check("rst_status1", {28'd0, busy[1], done[1], pass[1], tmo[1]}, 32'd0);
        check("rst_errs", {err_count[0], first_err_idx[0], first_err_idx[1]}, 32'd0);
        check("rst_vr", {30'd0, any_vr}, 32'd0);
        check("rst_payload", {30'd0, payload_nz}, 32'd0);

        // Mode 0, ideal slave
        run(0, 32'h0101FFFF, 1'b0, bc);
        check("m0_pass", 32'(pass[0]), 32'd1);
        check("m0_err", 32'(err_count[0]), 32'd0);
        check("m0_busy", 32'(busy[0]), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("m0_wdata%0d", i), w_log_v[0][i], exp039[i]);
        check("m0_aw_before_ar", 32'(aw_before_ar_v[0]), 32'd1);
        check("m0_n_ar", 32'(n_ar_v[0]), 32'd4);

        // Mode 1, ideal slave: all writes precede the first read
        do_reset();
        run(1, 32'h10203040, 1'b0, bc);
        check("m1_pass", 32'(pass[1]), 32'd1);
        check("m1_aw_before_ar", 32'(aw_before_ar_v[1]), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("m1_awaddr%0d", i), aw_log_v[1][i], 32'(i * 4));
        check("m1_wdata3", w_log_v[1][3], 32'h13233343);
        check("m1_n_ar", 32'(n_ar_v[1]), 32'd4);

        // Corrupted read of register 2
        do_reset();
        corrupt_en[0] = 1'b1;
        run(0, 32'h0101FFFF, 1'b0, bc);
        corrupt_en[0] = 1'b0;
        check("corr_err", 32'(err_count[0]), 32'd1);
        check("corr_first", 32'(first_err_idx[0]), 32'd2);
        check("corr_pass", 32'(pass[0]), 32'd0);
        check("corr_tmo", 32'(tmo[0]), 32'd0);

        // Delayed AWREADY, plus a start pulse while busy that must be ignored
        do_reset();
        aw_delay[0] = 8'd5;
        run(0, 32'h00000000, 1'b1, bc);
        check("awdly_pass", 32'(pass[0]), 32'd1);
        check("awdly_n_aw", 32'(n_aw_v[0]), 32'd4);
        check("awdly_n_w", 32'(n_w_v[0]), 32'd4);
        check("awdly_wdata1", w_log_v[0][1], 32'h01010101);
        // Delayed WREADY, restarted from done without reset
        aw_delay[0] = 8'd0;
        w_delay[0]  = 8'd5;
        run(0, 32'h11111111, 1'b0, bc);
        w_delay[0]  = 8'd0;
        check("wdly_pass", 32'(pass[0]), 32'd1);
        check("wdly_n_aw", 32'(n_aw_v[0]), 32'd8);
        check("wdly_n_w", 32'(n_w_v[0]), 32'd8);

        // No write response: timeout after 16 wait cycles
        do_reset();
        no_b[0] = 1'b1;
        run(0, 32'h0101FFFF, 1'b0, bc);
        check("tmo_flag", 32'(tmo[0]), 32'd1);
        check("tmo_done", 32'(done[0]), 32'd1);
        check("tmo_pass", 32'(pass[0]), 32'd0);
        check("tmo_vr", 32'(any_vr[0]), 32'd0);
        check("tmo_bready_cycles", 32'(bc), 32'd16);
        no_b[0] = 1'b0;

        // Reset asserted during a read-data wait, then a clean run
        do_reset();
        seen = 1'b0;
        @(negedge tb_ACLK);
        seed[0]  = 32'h0101FFFF;
        start[0] = 1'b1;
        @(negedge tb_ACLK);
        start[0] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rready_v[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge tb_ACLK);
        end
        check("mid_rdata_seen", 32'(seen), 32'd1);
        #2 tb_ARESETN = 1'b0;
        #1;
        check("async_busy", 32'(busy[0]), 32'd0);
        check("async_vr", 32'(any_vr[0]), 32'd0);
        check("async_payload", 32'(payload_nz[0]), 32'd0);
        @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
        run(0, 32'h0101FFFF, 1'b0, bc);
        check("post_rst_pass", 32'(pass[0]), 32'd1);
        check("post_rst_err", 32'(err_count[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
